// File: rtl/mppt_reg_bank_if.sv
// mppt_reg_bank_if
//   Byte-wide register access bus between the UART/Modbus RTU front end
//   (master) and the MPPT register bank (slave).
//   reg_addr   8  register address
//   reg_wdata  8  write data
//   reg_write  1  single-cycle write strobe
//   reg_read   1  single-cycle read strobe
//   reg_rdata  8  registered read data, valid the cycle after reg_read
interface mppt_reg_bank_if;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_write;
   logic       reg_read;
   logic [7:0] reg_rdata;

   modport master (
      output reg_addr,
      output reg_wdata,
      output reg_write,
      output reg_read,
      input  reg_rdata
   );

   modport slave (
      input  reg_addr,
      input  reg_wdata,
      input  reg_write,
      input  reg_read,
      output reg_rdata
   );
endinterface

// File: rtl/mppt_reg_bank.sv
// mppt_reg_bank
//   Modbus-visible register bank for the MPPT controller. Holds the control
//   registers driving the MPPT core, captures 16-bit measurements coherently
//   for byte-wise reads, latches fault flags and runs a communications
//   watchdog that drops mppt_enable when the host goes silent.
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   bus (slave)       register read/write strobes, address, data, read data
//   tick_1ms          single-cycle timebase pulse for the watchdog
//   pv_voltage/current/power  16-bit measurements (read via shadows)
//   mppt_locked       MPPT core tracking status
//   fault_in[3:0]     fault levels (OV, OC, OT, UV)
//   mppt_enable       CTRL[0] gated by the watchdog
//   manual_mode       CTRL[1]
//   duty_manual       manual duty command
//   vref, vref_update committed voltage reference and its one-cycle pulse
//   wdt_expired       watchdog expired flag
module mppt_reg_bank #(
   parameter logic [7:0]  DEVICE_ID   = 8'hA5,
   parameter int unsigned WDT_TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   mppt_reg_bank_if.slave bus,
   input  logic        tick_1ms,
   input  logic [15:0] pv_voltage,
   input  logic [15:0] pv_current,
   input  logic [15:0] pv_power,
   input  logic        mppt_locked,
   input  logic [3:0]  fault_in,
   output logic        mppt_enable,
   output logic        manual_mode,
   output logic [7:0]  duty_manual,
   output logic [15:0] vref,
   output logic        vref_update,
   output logic        wdt_expired
);

   localparam logic [15:0] WDT_LIMIT = 16'(WDT_TIMEOUT);

   localparam logic [7:0] A_ID      = 8'h00;
   localparam logic [7:0] A_CTRL    = 8'h01;
   localparam logic [7:0] A_STATUS  = 8'h02;
   localparam logic [7:0] A_FAULT   = 8'h03;
   localparam logic [7:0] A_DUTY    = 8'h04;
   localparam logic [7:0] A_VREF_LO = 8'h05;
   localparam logic [7:0] A_VREF_HI = 8'h06;
   localparam logic [7:0] A_PV_V_LO = 8'h10;
   localparam logic [7:0] A_PV_V_HI = 8'h11;
   localparam logic [7:0] A_PV_I_LO = 8'h12;
   localparam logic [7:0] A_PV_I_HI = 8'h13;
   localparam logic [7:0] A_PV_P_LO = 8'h14;
   localparam logic [7:0] A_PV_P_HI = 8'h15;
   localparam logic [7:0] A_SCRATCH = 8'h20;

   logic        wr;
   logic        rd;
   logic [7:0]  addr;
   logic [7:0]  wdata;

   logic [2:0]  ctrl;
   logic [3:0]  fault;
   logic [7:0]  duty;
   logic [7:0]  vref_lo;
   logic        vref_pending;
   logic [15:0] vref_q;
   logic        vref_upd_q;
   logic [7:0]  scratch;
   logic [15:0] sh_v;
   logic [15:0] sh_i;
   logic [15:0] sh_p;
   logic [15:0] wdt_cnt;
   logic [15:0] wdt_cnt_next;
   logic        wdt_exp;
   logic [7:0]  rdata_q;
   logic [7:0]  rdata_next;
   logic [3:0]  fault_clr;

   assign wr    = bus.reg_write;
   assign rd    = bus.reg_read;
   assign addr  = bus.reg_addr;
   assign wdata = bus.reg_wdata;

   // ---------------------------------------------------------------------
   // Read path: the mux sees pre-write state, so a simultaneous read and
   // write returns the old value. LO reads return the live input, which is
   // the same value being captured into the shadow on this edge.
   // ---------------------------------------------------------------------
   always_comb begin
      rdata_next = 8'h00;
      unique case (addr)
         A_ID:      rdata_next = DEVICE_ID;
         A_CTRL:    rdata_next = {5'b0, ctrl};
         A_STATUS:  rdata_next = {5'b0, vref_pending, wdt_exp, mppt_locked};
         A_FAULT:   rdata_next = {4'b0, fault};
         A_DUTY:    rdata_next = duty;
         A_VREF_LO: rdata_next = vref_lo;
         A_VREF_HI: rdata_next = vref_q[15:8];
         A_PV_V_LO: rdata_next = pv_voltage[7:0];
         A_PV_V_HI: rdata_next = sh_v[15:8];
         A_PV_I_LO: rdata_next = pv_current[7:0];
         A_PV_I_HI: rdata_next = sh_i[15:8];
         A_PV_P_LO: rdata_next = pv_power[7:0];
         A_PV_P_HI: rdata_next = sh_p[15:8];
         A_SCRATCH: rdata_next = scratch;
         default:   rdata_next = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= 8'h00;
         sh_v    <= 16'h0000;
         sh_i    <= 16'h0000;
         sh_p    <= 16'h0000;
      end else if (rd) begin
         rdata_q <= rdata_next;
         if (addr == A_PV_V_LO) sh_v <= pv_voltage;
         if (addr == A_PV_I_LO) sh_i <= pv_current;
         if (addr == A_PV_P_LO) sh_p <= pv_power;
      end
   end

   // ---------------------------------------------------------------------
   // Control / configuration registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl         <= 3'b001;
         duty         <= 8'h80;
         vref_lo      <= 8'h00;
         vref_pending <= 1'b0;
         vref_q       <= 16'h0000;
         vref_upd_q   <= 1'b0;
         scratch      <= 8'h00;
      end else begin
         vref_upd_q <= 1'b0;
         if (wr) begin
            unique case (addr)
               A_CTRL:    ctrl <= wdata[2:0];
               A_DUTY:    duty <= wdata;
               A_VREF_LO: begin
                  vref_lo      <= wdata;
                  vref_pending <= 1'b1;
               end
               A_VREF_HI: begin
                  vref_q       <= {wdata, vref_lo};
                  vref_pending <= 1'b0;
                  vref_upd_q   <= 1'b1;
               end
               A_SCRATCH: scratch <= wdata;
               default:   ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // Sticky faults: a live fault level always wins over a W1C clear.
   // ---------------------------------------------------------------------
   assign fault_clr = (wr && addr == A_FAULT) ? wdata[3:0] : 4'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault <= 4'h0;
      end else begin
         fault <= (fault & ~fault_clr) | fault_in;
      end
   end

   // ---------------------------------------------------------------------
   // Communications watchdog: up-count of tick_1ms periods since the last
   // host access, saturating at the limit.
   // ---------------------------------------------------------------------
   always_comb begin
      wdt_cnt_next = wdt_cnt;
      if (rd || wr || !ctrl[2]) begin
         wdt_cnt_next = 16'h0000;
      end else if (tick_1ms && wdt_cnt < WDT_LIMIT) begin
         wdt_cnt_next = wdt_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdt_cnt <= 16'h0000;
         wdt_exp <= 1'b0;
      end else begin
         wdt_cnt <= wdt_cnt_next;
         // Only a CTRL write re-arms; disabling the watchdog leaves the flag.
         if (wr && addr == A_CTRL) begin
            wdt_exp <= 1'b0;
         end else if (wdt_cnt_next == WDT_LIMIT) begin
            wdt_exp <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.reg_rdata = rdata_q;
   assign mppt_enable   = ctrl[0] & ~wdt_exp;
   assign manual_mode   = ctrl[1];
   assign duty_manual   = duty;
   assign vref          = vref_q;
   assign vref_update   = vref_upd_q;
   assign wdt_expired   = wdt_exp;

endmodule

// File: tb/tb_mppt_reg_bank.sv
// tb_mppt_reg_bank
//   Scoreboard bench for mppt_reg_bank: a reference model of the register
//   map pushes expected read data into a queue on every read strobe; a
//   monitor on the falling edge pops and compares, and also compares the
//   control outputs against the model every cycle.
module tb_mppt_reg_bank;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick_1ms = 1'b0;
   logic [15:0] pv_voltage = 16'h0;
   logic [15:0] pv_current = 16'h0;
   logic [15:0] pv_power = 16'h0;
   logic        mppt_locked = 1'b0;
   logic [3:0]  fault_in = 4'h0;
   logic        mppt_enable;
   logic        manual_mode;
   logic [7:0]  duty_manual;
   logic [15:0] vref;
   logic        vref_update;
   logic        wdt_expired;

   mppt_reg_bank_if bus();

   always #5 clk = ~clk;

   mppt_reg_bank #(.DEVICE_ID(8'hA5), .WDT_TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .tick_1ms    (tick_1ms),
      .pv_voltage  (pv_voltage),
      .pv_current  (pv_current),
      .pv_power    (pv_power),
      .mppt_locked (mppt_locked),
      .fault_in    (fault_in),
      .mppt_enable (mppt_enable),
      .manual_mode (manual_mode),
      .duty_manual (duty_manual),
      .vref        (vref),
      .vref_update (vref_update),
      .wdt_expired (wdt_expired)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (register map as plain integers) ---
   int m_ctrl, m_fault, m_duty, m_lo, m_pend, m_vref, m_upd, m_scratch;
   int m_wcnt, m_exp;
   int m_sh[3];
   int exp_q[$];
   int last_rd;

   function automatic int pv_of(int idx);
      case (idx)
         0: return int'(pv_voltage);
         1: return int'(pv_current);
         default: return int'(pv_power);
      endcase
   endfunction

   task automatic model_reset();
      m_ctrl = 1; m_fault = 0; m_duty = 'h80; m_lo = 0; m_pend = 0;
      m_vref = 0; m_upd = 0; m_scratch = 0; m_wcnt = 0; m_exp = 0;
      for (int i = 0; i < 3; i++) m_sh[i] = 0;
      exp_q.delete();
      last_rd = 0;
   endtask

   task automatic model_step();
      int a, wd, rv, clr, idx;
      bit rd, wr;
      a  = int'(bus.reg_addr);
      wd = int'(bus.reg_wdata);
      rd = bus.reg_read;
      wr = bus.reg_write;
      if (rd) begin
         rv = 0;
         if (a == 0) rv = 'hA5;
         else if (a == 1) rv = m_ctrl;
         else if (a == 2) rv = int'(mppt_locked) + 2 * m_exp + 4 * m_pend;
         else if (a == 3) rv = m_fault;
         else if (a == 4) rv = m_duty;
         else if (a == 5) rv = m_lo;
         else if (a == 6) rv = m_vref / 256;
         else if (a >= 'h10 && a <= 'h15) begin
            idx = (a - 'h10) / 2;
            if (a % 2 == 0) begin
               m_sh[idx] = pv_of(idx);
               rv = m_sh[idx] % 256;
            end else begin
               rv = m_sh[idx] / 256;
            end
         end
         else if (a == 'h20) rv = m_scratch;
         exp_q.push_back(rv);
      end
      clr = 0;
      m_upd = 0;
      if (wr) begin
         if (a == 1) begin m_ctrl = wd % 8; m_exp = 0; end
         else if (a == 3) clr = wd % 16;
         else if (a == 4) m_duty = wd;
         else if (a == 5) begin m_lo = wd; m_pend = 1; end
         else if (a == 6) begin m_vref = wd * 256 + m_lo; m_pend = 0; m_upd = 1; end
         else if (a == 'h20) m_scratch = wd;
      end
      m_fault = (m_fault & ~clr) | int'(fault_in);
      if (rd || wr || (m_ctrl & 4) == 0) m_wcnt = 0;
      else if (tick_1ms && m_wcnt < TO) m_wcnt++;
      if (m_wcnt == TO && !(wr && a == 1)) m_exp = 1;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- monitor ---------------------------------------------
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (exp_q.size() > 0) last_rd = exp_q.pop_front();
            chk("rdata", 32'(bus.reg_rdata), 32'(last_rd));
            chk("mppt_enable", 32'(mppt_enable), 32'((m_ctrl & 1) != 0 && m_exp == 0));
            chk("manual_mode", 32'(manual_mode), 32'((m_ctrl & 2) != 0));
            chk("duty_manual", 32'(duty_manual), 32'(m_duty));
            chk("vref", 32'(vref), 32'(m_vref));
            chk("vref_update", 32'(vref_update), 32'(m_upd));
            chk("wdt_expired", 32'(wdt_expired), 32'(m_exp));
         end
      end
   end

   // ---------------- stimulus --------------------------------------------
   task automatic op(input bit rd, input bit wr, input int a, input int d, input bit tk);
      @(negedge clk);
      bus.reg_read  = rd;
      bus.reg_write = wr;
      bus.reg_addr  = 8'(a);
      bus.reg_wdata = 8'(d);
      tick_1ms      = tk;
      @(negedge clk);
      bus.reg_read  = 1'b0;
      bus.reg_write = 1'b0;
      tick_1ms      = 1'b0;
   endtask

   task automatic rd_chk(input string name, input int a, input int exp);
      op(1, 0, a, 0, 0);
      chk(name, 32'(bus.reg_rdata), 32'(exp));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rdata"}, 32'(bus.reg_rdata), 32'h00);
      chk({tag, "_en"}, 32'(mppt_enable), 32'h1);
      chk({tag, "_manual"}, 32'(manual_mode), 32'h0);
      chk({tag, "_duty"}, 32'(duty_manual), 32'h80);
      chk({tag, "_vref"}, 32'(vref), 32'h0000);
      chk({tag, "_upd"}, 32'(vref_update), 32'h0);
      chk({tag, "_wdt"}, 32'(wdt_expired), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      bus.reg_read  = 1'b0;
      bus.reg_write = 1'b0;
      bus.reg_addr  = 8'h00;
      bus.reg_wdata = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      rd_chk("id", 'h00, 'hA5);
      rd_chk("ctrl_rst", 'h01, 'h01);
      rd_chk("duty_rst", 'h04, 'h80);

      pv_voltage = 16'h1234;
      rd_chk("pv_v_lo", 'h10, 'h34);
      pv_voltage = 16'hABCD;
      rd_chk("pv_v_hi", 'h11, 'h12);
      rd_chk("pv_i_hi_noprior", 'h13, 'h00);

      op(0, 1, 'h05, 'hE8, 0);
      rd_chk("status_pend", 'h02, 'h04);
      chk("vref_hold", 32'(vref), 32'h0000);
      op(0, 1, 'h06, 'h03, 0);
      chk("vref_commit", 32'(vref), 32'h03E8);
      chk("vref_pulse", 32'(vref_update), 32'h1);
      @(negedge clk);
      chk("vref_pulse_end", 32'(vref_update), 32'h0);
      rd_chk("status_clr", 'h02, 'h00);
      rd_chk("vref_hi_rd", 'h06, 'h03);

      @(negedge clk) fault_in = 4'h2;
      @(negedge clk) fault_in = 4'h0;
      rd_chk("fault_set", 'h03, 'h02);
      fault_in = 4'h2;
      op(0, 1, 'h03, 'h02, 0);
      fault_in = 4'h0;
      rd_chk("fault_setwins", 'h03, 'h02);
      op(0, 1, 'h03, 'h02, 0);
      rd_chk("fault_clr", 'h03, 'h00);

      op(0, 1, 'h01, 'h05, 0);
      repeat (4) op(0, 0, 0, 0, 1);
      chk("wdt_expire", 32'(wdt_expired), 32'h1);
      chk("wdt_en_drop", 32'(mppt_enable), 32'h0);
      op(0, 1, 'h01, 'h05, 0);
      chk("wdt_recover", 32'(wdt_expired), 32'h0);
      chk("wdt_en_back", 32'(mppt_enable), 32'h1);
      repeat (3) op(0, 0, 0, 0, 1);
      op(1, 0, 'h00, 0, 0);
      repeat (3) op(0, 0, 0, 0, 1);
      chk("wdt_kicked", 32'(wdt_expired), 32'h0);
      op(0, 0, 0, 0, 1);
      chk("wdt_second_expire", 32'(wdt_expired), 32'h1);
      op(0, 1, 'h01, 'h01, 0);

      op(0, 1, 'h20, 'h5A, 0);
      rd_chk("scratch", 'h20, 'h5A);
      rd_chk("unmapped", 'h7F, 'h00);
      op(0, 1, 'h00, 'hFF, 0);
      rd_chk("id_ro", 'h00, 'hA5);
      op(1, 1, 'h20, 'h33, 0);
      chk("rdwr_prewrite", 32'(bus.reg_rdata), 32'h5A);
      rd_chk("rdwr_post", 'h20, 'h33);

      // Randomised traffic across mapped and unmapped addresses.
      for (int i = 0; i < 3000; i++) begin
         int sel;
         @(negedge clk);
         sel = $urandom_range(0, 15);
         case (sel)
            0, 1, 2, 3, 4, 5, 6: bus.reg_addr = 8'(sel);
            7, 8, 9: bus.reg_addr = 8'h10 + 8'($urandom_range(0, 5));
            10, 11: bus.reg_addr = 8'h20;
            default: bus.reg_addr = 8'($urandom_range(0, 255));
         endcase
         bus.reg_wdata = 8'($urandom);
         bus.reg_read  = ($urandom_range(0, 3) == 0);
         bus.reg_write = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 3) != 0) begin
            bus.reg_read  = 1'b0;
            bus.reg_write = 1'b0;
         end
         tick_1ms    = ($urandom_range(0, 2) == 0);
         fault_in    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
         mppt_locked = 1'($urandom);
         pv_voltage  = 16'($urandom);
         pv_current  = 16'($urandom);
         pv_power    = 16'($urandom);
      end
      @(negedge clk);
      bus.reg_read  = 1'b0;
      bus.reg_write = 1'b0;
      tick_1ms      = 1'b0;
      fault_in      = 4'h0;

      // Asynchronous reset in the middle of a write.
      op(0, 1, 'h04, 'h11, 0);
      @(negedge clk);
      bus.reg_write = 1'b1;
      bus.reg_addr  = 8'h20;
      bus.reg_wdata = 8'hC3;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async");
      @(negedge clk);
      bus.reg_write = 1'b0;
      rst_n = 1'b1;
      rd_chk("async_scratch", 'h20, 'h00);
      rd_chk("async_duty", 'h04, 'h80);
      rd_chk("async_ctrl", 'h01, 'h01);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mppt_reg_bank.md
# mppt_reg_bank

Modbus-visible register bank for the MPPT controller. Sits directly downstream of the UART/Modbus RTU front end: it consumes its single-byte register read/write strobes, returns read data, and exposes control registers (enable, manual duty, voltage reference) to the MPPT core. It captures measurements coherently for byte-wise reads, latches fault flags, and runs a communications watchdog that drops MPPT enable if the host goes silent.

## Interface
- DEVICE_ID, 8'hA5, constant returned at address 0x00
- WDT_TIMEOUT, 1000, watchdog limit in tick_1ms periods (16-bit counter)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- reg_addr  in  8  register address from Modbus front end
- reg_wdata  in  8  write data
- reg_write  in  1  single-cycle write strobe
- reg_read  in  1  single-cycle read strobe
- reg_rdata  out  8  read data, registered
- tick_1ms  in  1  single-cycle timebase pulse
- pv_voltage  in  16  measured PV voltage
- pv_current  in  16  measured PV current
- pv_power  in  16  computed PV power
- mppt_locked  in  1  MPPT core tracking status
- fault_in  in  4  fault level inputs (OV, OC, OT, UV)
- mppt_enable  out  1  CTRL[0] & ~wdt_expired
- manual_mode  out  1  CTRL[1]
- duty_manual  out  8  manual duty command
- vref  out  16  committed voltage reference
- vref_update  out  1  one-cycle pulse when vref changes
- wdt_expired  out  1  watchdog expired flag

## Operation
- Address map (all others: read 0x00, write ignored):
  - 0x00 ID, RO, DEVICE_ID
  - 0x01 CTRL, RW, [0] mppt_en, [1] manual_mode, [2] wdt_en, [7:3] read 0; reset 0x01
  - 0x02 STATUS, RO, [0] mppt_locked, [1] wdt_expired, [2] vref_pending
  - 0x03 FAULT, W1C, [3:0] sticky fault flags; reset 0x0
  - 0x04 DUTY_MAN, RW, reset 0x80
  - 0x05 VREF_LO, RW staging byte; write sets vref_pending
  - 0x06 VREF_HI, write commits vref = {wdata, staged LO}, clears vref_pending, pulses vref_update; read returns vref[15:8]
  - 0x10/0x11 PV_V LO/HI, 0x12/0x13 PV_I LO/HI, 0x14/0x15 PV_P LO/HI, RO
  - 0x20 SCRATCH, RW, reset 0x00
- Coherent reads: reading a LO address captures the full 16-bit input into that pair's shadow register and returns bits [7:0]; reading the HI address returns shadow [15:8]. HI read without prior LO returns shadow (reset 0x0000).
- Faults: each FAULT bit is set on any cycle its fault_in bit is 1; cleared by writing 1 to that bit. Set and clear in the same cycle: set wins.
- Watchdog: 16-bit counter cleared on any reg_read or reg_write; increments on tick_1ms while CTRL[2]=1, saturating at WDT_TIMEOUT. Reaching WDT_TIMEOUT sets wdt_expired. wdt_expired is cleared only by a write to CTRL. CTRL[2]=0 holds counter at 0 and does not clear wdt_expired.
- reg_read and reg_write asserted together: write performed, read returns pre-write value.

## Timing
- Reset values: reg_rdata 0x00, mppt_enable 1, manual_mode 0, duty_manual 0x80, vref 0x0000, vref_update 0, wdt_expired 0; shadows, staging, FAULT, SCRATCH, counter 0.
- Read latency: reg_rdata valid on the cycle after reg_read; held until next reg_read.
- Writes: register outputs update on the cycle after reg_write.
- vref_update: high exactly one cycle, the cycle vref takes its new value.
- Watchdog: wdt_expired and mppt_enable=0 on the cycle after the tick_1ms that brings the counter to WDT_TIMEOUT.
- Async reset mid-transaction aborts it; all state returns to reset values immediately.

## Test plan
- Reset, read 0x00, 0x01, 0x04 -> rdata 0xA5, 0x01, 0x80 one cycle after each reg_read.
- pv_voltage=0x1234, read 0x10, change input to 0xABCD, read 0x11 -> 0x34 then 0x12.
- Write 0x05=0xE8 -> STATUS[2]=1, vref unchanged; write 0x06=0x03 -> vref=0x03E8, one-cycle vref_update, STATUS[2]=0.
- Pulse fault_in[1], read 0x03 -> 0x02; write 0x02 while fault_in[1]=1 -> stays 0x02; release, write 0x02 -> 0x00.
- WDT_TIMEOUT=4, CTRL=0x05, 4 ticks with no access -> wdt_expired=1, mppt_enable=0; write CTRL=0x05 -> both recover; 3 ticks, one read, 3 ticks -> no expiry.
- Write 0x20=0x5A, read 0x20 -> 0x5A; read 0x7F -> 0x00; write 0x00=0xFF -> ID still 0xA5.
